// File: rtl/wt_dcache_rd_arb_if.sv
// wt_dcache_rd_arb_if
//   Bundles the read-port side (per-controller request/ack/result-valid)
//   and the memory side (muxed request plus memory ack) of the dcache read
//   arbiter.
//   slave  : the arbiter (consumes controller requests and memory ack).
//   master : the environment (controllers plus memory model).
// Signals
//   rd_req      NumPorts        per-port read request (level)
//   rd_tag_only NumPorts        per-port tag-only read
//   rd_idx      NumPorts x IdxW per-port cache-line index
//   rd_off      NumPorts x OffW per-port byte offset
//   rd_tag      NumPorts x TagW per-port tag (valid the cycle after ack)
//   rd_ack      NumPorts        per-port ack, one-hot or zero
//   rd_rvld     NumPorts        per-port result valid, one cycle after ack
//   mem_req     1               request to dcache memory
//   mem_tag_only,mem_idx,mem_off,mem_tag  muxed request fields
//   mem_ack     1               memory accepted the read this cycle
interface wt_dcache_rd_arb_if #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned IdxW     = 8,
  parameter int unsigned OffW     = 4,
  parameter int unsigned TagW     = 44
);
  logic [NumPorts-1:0]           rd_req;
  logic [NumPorts-1:0]           rd_tag_only;
  logic [NumPorts-1:0][IdxW-1:0] rd_idx;
  logic [NumPorts-1:0][OffW-1:0] rd_off;
  logic [NumPorts-1:0][TagW-1:0] rd_tag;
  logic [NumPorts-1:0]           rd_ack;
  logic [NumPorts-1:0]           rd_rvld;

  logic                          mem_req;
  logic                          mem_tag_only;
  logic [IdxW-1:0]               mem_idx;
  logic [OffW-1:0]               mem_off;
  logic [TagW-1:0]               mem_tag;
  logic                          mem_ack;

  modport slave (
    input  rd_req, rd_tag_only, rd_idx, rd_off, rd_tag, mem_ack,
    output rd_ack, rd_rvld, mem_req, mem_tag_only, mem_idx, mem_off, mem_tag
  );

  modport master (
    output rd_req, rd_tag_only, rd_idx, rd_off, rd_tag, mem_ack,
    input  rd_ack, rd_rvld, mem_req, mem_tag_only, mem_idx, mem_off, mem_tag
  );
endinterface

// File: rtl/wt_dcache_rd_arb.sv
// wt_dcache_rd_arb
//   Round-robin arbiter sharing the single L1 dcache memory read port among
//   NumPorts read controllers. The winner's index/offset/tag-only flag are
//   muxed combinationally to memory; the tag is steered by the registered
//   winner one cycle after ack. A stalled winner is held until memory
//   accepts it or the port withdraws its request.
// Ports
//   clk_i   in  clock
//   rst_ni  in  synchronous reset, active low
//   bus     wt_dcache_rd_arb_if.slave (see interface header)
module wt_dcache_rd_arb #(
  parameter int unsigned NumPorts = 3,
  parameter int unsigned IdxW     = 8,
  parameter int unsigned OffW     = 4,
  parameter int unsigned TagW     = 44
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wt_dcache_rd_arb_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(NumPorts);

  logic [PtrW-1:0] rr_ptr_q, hold_port_q, win_q, win, rr_ptr_nxt;
  logic [PtrW:0]   cand_ext;
  logic [PtrW-1:0] cand;
  logic            hold_q, rvld_q, found, accept;

  // A held winner keeps priority while it still requests; otherwise scan
  // rr_ptr_q, rr_ptr_q+1, ... modulo NumPorts for the first requester.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    cand_ext = '0;
    cand     = '0;
    if (hold_q && bus.rd_req[hold_port_q]) begin
      win = hold_port_q;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        cand_ext = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
        if (cand_ext >= (PtrW+1)'(NumPorts)) cand_ext = cand_ext - (PtrW+1)'(NumPorts);
        cand = cand_ext[PtrW-1:0];
        if (!found && bus.rd_req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  assign bus.mem_req      = |bus.rd_req;
  assign bus.mem_idx      = bus.rd_idx[win];
  assign bus.mem_off      = bus.rd_off[win];
  assign bus.mem_tag_only = bus.rd_tag_only[win];
  // Memory compares the tag the cycle after ack, so the registered winner
  // owns the tag bus in that cycle even if a new grant happens alongside.
  assign bus.mem_tag      = rvld_q ? bus.rd_tag[win_q] : bus.rd_tag[win];

  assign accept     = bus.mem_req & bus.mem_ack;
  assign rr_ptr_nxt = (win == PtrW'(NumPorts-1)) ? '0 : win + PtrW'(1);

  always_comb begin
    bus.rd_ack      = '0;
    bus.rd_ack[win] = accept & rst_ni;
  end

  always_comb begin
    bus.rd_rvld        = '0;
    bus.rd_rvld[win_q] = rvld_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      hold_port_q <= '0;
      win_q       <= '0;
      rvld_q      <= 1'b0;
    end else if (accept) begin
      rr_ptr_q <= rr_ptr_nxt;
      win_q    <= win;
      rvld_q   <= 1'b1;
      hold_q   <= 1'b0;
    end else if (bus.mem_req) begin
      hold_q      <= 1'b1;
      hold_port_q <= win;
      rvld_q      <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      rvld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ($onehot0(bus.rd_ack))  else $error("rd_ack not onehot0");
      assert ($onehot0(bus.rd_rvld)) else $error("rd_rvld not onehot0");
      assert (!(bus.mem_ack && !bus.mem_req)) else $error("memory ack without request");
    end
  end
endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
module tb_wt_dcache_rd_arb;
  localparam int unsigned NumPorts = 3;
  localparam int unsigned IdxW     = 8;
  localparam int unsigned OffW     = 4;
  localparam int unsigned TagW     = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk_i = ~clk_i;

  wt_dcache_rd_arb_if #(.NumPorts(NumPorts), .IdxW(IdxW), .OffW(OffW), .TagW(TagW)) bus ();

  wt_dcache_rd_arb #(.NumPorts(NumPorts), .IdxW(IdxW), .OffW(OffW), .TagW(TagW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive inputs just after the edge, then settle before checking.
  task automatic drive(input logic [2:0] req, input logic ack);
    bus.rd_req  = req;
    bus.mem_ack = ack;
    #1;
  endtask

  logic [2:0] exp_ack, exp_rvld;

  initial begin
    rst_ni      = 1'b0;
    bus.rd_req  = '0;
    bus.mem_ack = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      bus.rd_idx[p]      = IdxW'(8'h10 + p);
      bus.rd_off[p]      = OffW'(p + 1);
      bus.rd_tag[p]      = TagW'(8'hA + p);
      bus.rd_tag_only[p] = (p == 1);
    end

    // Reset held two cycles with every port requesting.
    tick(); drive(3'b111, 1'b1);
    chk("rst_ack0",  32'(bus.rd_ack),  32'h0);
    chk("rst_rvld0", 32'(bus.rd_rvld), 32'h0);
    tick(); drive(3'b111, 1'b1);
    chk("rst_ack1",  32'(bus.rd_ack),  32'h0);
    chk("rst_rvld1", 32'(bus.rd_rvld), 32'h0);

    // Release: round robin 0,1,2,0,1,2 with rvld trailing by one cycle.
    tick(); rst_ni = 1'b1; drive(3'b111, 1'b1);
    chk("first_idx", 32'(bus.mem_idx), 32'h10);
    chk("first_req", 32'(bus.mem_req), 32'h1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin tick(); drive(3'b111, 1'b1); end
      exp_ack  = 3'b001 << (k % 3);
      exp_rvld = (k == 0) ? 3'b000 : (3'b001 << ((k - 1) % 3));
      chk($sformatf("rr_ack%0d", k),  32'(bus.rd_ack),  32'(exp_ack));
      chk($sformatf("rr_rvld%0d", k), 32'(bus.rd_rvld), 32'(exp_rvld));
    end
    tick(); drive(3'b000, 1'b0);
    chk("rr_tail_rvld", 32'(bus.rd_rvld), 32'h4);
    chk("idle_ack",     32'(bus.rd_ack),  32'h0);
    chk("idle_req",     32'(bus.mem_req), 32'h0);
    tick(); drive(3'b000, 1'b0);
    chk("idle_rvld", 32'(bus.rd_rvld), 32'h0);

    // Stall on port 1; port 0 joins in the third stall cycle.
    for (int c = 0; c < 4; c++) begin
      tick(); drive((c >= 2) ? 3'b011 : 3'b010, 1'b0);
      chk($sformatf("stall_idx%0d", c), 32'(bus.mem_idx), 32'h11);
      chk($sformatf("stall_ack%0d", c), 32'(bus.rd_ack),  32'h0);
    end
    chk("stall_tag_only", 32'(bus.mem_tag_only), 32'h1);
    tick(); drive(3'b011, 1'b1);
    chk("stall_release_ack", 32'(bus.rd_ack), 32'h2);
    tick(); drive(3'b001, 1'b1);
    chk("after_stall_ack",  32'(bus.rd_ack),  32'h1);
    chk("after_stall_rvld", 32'(bus.rd_rvld), 32'h2);
    chk("after_stall_tonly", 32'(bus.mem_tag_only), 32'h0);
    tick(); drive(3'b000, 1'b0);
    chk("after_stall_rvld2", 32'(bus.rd_rvld), 32'h1);

    // Held port 2 withdraws its request; mux moves to port 0 immediately.
    tick(); drive(3'b100, 1'b0);
    chk("kill_idx_hold", 32'(bus.mem_idx), 32'h12);
    tick(); drive(3'b001, 1'b0);
    chk("kill_idx_switch", 32'(bus.mem_idx), 32'h10);
    chk("kill_off_switch", 32'(bus.mem_off), 32'h1);
    chk("kill_no_ack",     32'(bus.rd_ack),  32'h0);
    tick(); drive(3'b001, 1'b1);
    chk("kill_ack0", 32'(bus.rd_ack), 32'h1);
    tick(); drive(3'b000, 1'b0);
    chk("kill_rvld0", 32'(bus.rd_rvld), 32'h1);

    // Back-to-back acks 0 then 1; tag bus follows the registered winner.
    tick(); drive(3'b001, 1'b1);
    chk("b2b_ack0", 32'(bus.rd_ack), 32'h1);
    tick(); drive(3'b010, 1'b1);
    chk("b2b_ack1", 32'(bus.rd_ack),  32'h2);
    chk("b2b_tagA", 32'(bus.mem_tag), 32'hA);
    tick(); drive(3'b000, 1'b0);
    chk("b2b_tagB",  32'(bus.mem_tag), 32'hB);
    chk("b2b_rvld1", 32'(bus.rd_rvld), 32'h2);

    // Port 1 alone, acked every cycle; port 2 then still wins next.
    for (int c = 0; c < 4; c++) begin
      tick(); drive(3'b010, 1'b1);
      chk($sformatf("solo_ack%0d", c), 32'(bus.rd_ack), 32'h2);
      if (c > 0) chk($sformatf("solo_rvld%0d", c), 32'(bus.rd_rvld), 32'h2);
    end
    tick(); drive(3'b110, 1'b1);
    chk("solo_then_p2_ack", 32'(bus.rd_ack), 32'h4);
    chk("solo_then_p2_idx", 32'(bus.mem_idx), 32'h12);
    tick(); drive(3'b010, 1'b1);
    chk("solo_then_p1_ack",  32'(bus.rd_ack),  32'h2);
    chk("solo_then_p1_rvld", 32'(bus.rd_rvld), 32'h4);

    // Reset while a result is pending drops it.
    tick(); rst_ni = 1'b0; drive(3'b000, 1'b0);
    chk("midrst_rvld_pre", 32'(bus.rd_rvld), 32'h2);
    tick(); drive(3'b000, 1'b0);
    chk("midrst_rvld", 32'(bus.rd_rvld), 32'h0);
    tick(); rst_ni = 1'b1; drive(3'b110, 1'b1);
    chk("midrst_ptr0_ack", 32'(bus.rd_ack), 32'h2);
    tick(); drive(3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
